// File: rtl/stump_control_if.sv
// Bundle between the Stump control unit and the datapath/memory side:
// instruction, ALU flags and memory handshake in; control strobes out.
interface stump_control_if;
    logic [15:0] ir;
    logic [3:0]  alu_flags;
    logic        mem_ready;
    logic [1:0]  state;
    logic [3:0]  cc;
    logic [2:0]  alu_func;
    logic        alu_c_in;
    logic        ir_en;
    logic        pc_inc;
    logic        reg_write;
    logic [2:0]  reg_dst;
    logic        mem_rd;
    logic        mem_wr;
    logic        addr_sel;

    modport master (
        output ir, alu_flags, mem_ready,
        input  state, cc, alu_func, alu_c_in, ir_en, pc_inc,
               reg_write, reg_dst, mem_rd, mem_wr, addr_sel
    );

    modport slave (
        input  ir, alu_flags, mem_ready,
        output state, cc, alu_func, alu_c_in, ir_en, pc_inc,
               reg_write, reg_dst, mem_rd, mem_wr, addr_sel
    );
endinterface

// File: rtl/stump_control.sv
// Stump sequencer: fetch/execute/memory FSM, instruction decode, NZVC flag
// register and branch-condition evaluation.
module stump_control #(
    parameter logic [3:0] RESET_CC = 4'b0000
) (
    input  logic             clk,
    input  logic             rst_n,
    stump_control_if.slave   bus
);

    localparam logic [1:0] ST_FETCH   = 2'b00;
    localparam logic [1:0] ST_EXECUTE = 2'b01;
    localparam logic [1:0] ST_MEMORY  = 2'b10;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_ADC = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_SBC = 3'b011;
    localparam logic [2:0] OP_MEM = 3'b110;
    localparam logic [2:0] OP_BR  = 3'b111;

    logic [1:0] state_q, state_d;
    logic [3:0] cc_q, cc_d;

    logic [2:0] op;
    logic       s_bit;
    logic [2:0] dst;
    logic [3:0] cond;
    logic       is_load;
    logic       cond_true;
    logic       flag_n, flag_z, flag_v, flag_c;
    logic       unused_ir_bits;

    logic [2:0] alu_func;
    logic       alu_c_in;
    logic       ir_en;
    logic       pc_inc;
    logic       reg_write;
    logic [2:0] reg_dst;
    logic       mem_rd;
    logic       mem_wr;
    logic       addr_sel;

    assign op             = bus.ir[15:13];
    assign s_bit          = bus.ir[12];
    assign dst            = bus.ir[10:8];
    assign cond           = bus.ir[11:8];
    assign is_load        = bus.ir[12];
    assign unused_ir_bits = ^bus.ir[7:0];

    assign {flag_n, flag_z, flag_v, flag_c} = cc_q;

    // Branches test the architectural flags, not the ALU's live outputs.
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            4'h0: cond_true = 1'b1;
            4'h1: cond_true = 1'b0;
            4'h2: cond_true = !flag_c && !flag_z;
            4'h3: cond_true = flag_c || flag_z;
            4'h4: cond_true = !flag_c;
            4'h5: cond_true = flag_c;
            4'h6: cond_true = !flag_z;
            4'h7: cond_true = flag_z;
            4'h8: cond_true = !flag_v;
            4'h9: cond_true = flag_v;
            4'hA: cond_true = !flag_n;
            4'hB: cond_true = flag_n;
            4'hC: cond_true = (flag_n == flag_v);
            4'hD: cond_true = (flag_n != flag_v);
            4'hE: cond_true = !flag_z && (flag_n == flag_v);
            4'hF: cond_true = flag_z || (flag_n != flag_v);
            default: cond_true = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cc_d      = cc_q;
        alu_func  = OP_ADD;
        alu_c_in  = 1'b0;
        ir_en     = 1'b0;
        pc_inc    = 1'b0;
        reg_write = 1'b0;
        reg_dst   = 3'd0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        addr_sel  = 1'b0;

        case (state_q)
            ST_FETCH: begin
                // Gated by rst_n so no fetch is requested or completed in reset.
                mem_rd = rst_n;
                if (bus.mem_ready && rst_n) begin
                    ir_en   = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = ST_EXECUTE;
                end
            end

            ST_EXECUTE: begin
                case (op)
                    OP_ADC, OP_SBC: alu_c_in = cc_q[0];
                    OP_SUB:         alu_c_in = 1'b1;
                    default:        alu_c_in = 1'b0;
                endcase

                if (op == OP_MEM) begin
                    state_d = ST_MEMORY;
                end else if (op == OP_BR) begin
                    state_d = ST_FETCH;
                    if (cond_true) begin
                        reg_write = 1'b1;
                        reg_dst   = 3'd7;
                    end
                end else begin
                    alu_func  = op;
                    reg_write = 1'b1;
                    reg_dst   = dst;
                    state_d   = ST_FETCH;
                    if (s_bit) begin
                        cc_d = bus.alu_flags;
                    end
                end
            end

            ST_MEMORY: begin
                addr_sel = 1'b1;
                if (is_load) begin
                    mem_rd = 1'b1;
                    if (bus.mem_ready) begin
                        reg_write = 1'b1;
                        reg_dst   = dst;
                    end
                end else begin
                    mem_wr = 1'b1;
                end
                if (bus.mem_ready) begin
                    state_d = ST_FETCH;
                end
            end

            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            cc_q    <= RESET_CC;
        end else begin
            state_q <= state_d;
            cc_q    <= cc_d;
        end
    end

    assign bus.state     = state_q;
    assign bus.cc        = cc_q;
    assign bus.alu_func  = alu_func;
    assign bus.alu_c_in  = alu_c_in;
    assign bus.ir_en     = ir_en;
    assign bus.pc_inc    = pc_inc;
    assign bus.reg_write = reg_write;
    assign bus.reg_dst   = reg_dst;
    assign bus.mem_rd    = mem_rd;
    assign bus.mem_wr    = mem_wr;
    assign bus.addr_sel  = addr_sel;

endmodule
